mem_access_unit: RTL

- Load/store sequencer directly downstream of the MMU.
- Takes a load/store request from the execute stage and drives the MMU's address-valid/virtual-address inputs.
- One cycle later it consumes the MMU's translated physical address, IO flag and exception code.
- For translated, aligned accesses it runs a single word-wide bus transaction with byte enables, lane extraction, sign extension and a timeout. It returns data or an exception code to the pipeline.

---
 rtl/mem_access_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer sitting behind the MMU: issues the translation strobe, then runs one
// word-wide bus transaction with lane steering, load extension and a bus timeout.
module mem_access_unit #(
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        res,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] vaddr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [2:0]  exc,
    output logic        mmu_addr_valid,
    output logic [31:0] mmu_vaddr,
    output logic        mmu_write,
    input  logic [31:0] mmu_paddr,
    input  logic        mmu_io,
    input  logic [1:0]  mmu_exc,
    output logic        bus_req,
    output logic        bus_io,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_TRANS, S_BUS, S_DONE} state_t;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_ADEL = 3'd1;
    localparam logic [2:0] EXC_ADES = 3'd2;
    localparam logic [2:0] EXC_BUS  = 3'd6;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic                 we_q, we_d;
    logic [1:0]           size_q, size_d;
    logic                 sext_q, sext_d;
    logic [1:0]           off_q, off_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 bus_req_q, bus_req_d;
    logic                 bus_io_q, bus_io_d;
    logic                 bus_we_q, bus_we_d;
    logic [31:0]          bus_addr_q, bus_addr_d;
    logic [3:0]           bus_be_q, bus_be_d;
    logic [31:0]          bus_wdata_q, bus_wdata_d;
    logic [2:0]           exc_q, exc_d;
    logic [31:0]          rdata_q, rdata_d;

    logic                 misaligned;
    logic [31:0]          shifted;
    logic [31:0]          load_val;
    logic                 unused_paddr_bits;

    assign unused_paddr_bits = ^mmu_paddr[1:0];

    always_comb begin
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = vaddr[0];
            default: misaligned = |vaddr[1:0];
        endcase
    end

    // Bring the addressed lane down to bit 0, then truncate and extend to the access size.
    always_comb begin
        shifted = bus_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_val = {{24{sext_q & shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d        = state_q;
        we_d           = we_q;
        size_d         = size_q;
        sext_d         = sext_q;
        off_d          = off_q;
        wdata_d        = wdata_q;
        cnt_d          = cnt_q;
        bus_req_d      = bus_req_q;
        bus_io_d       = bus_io_q;
        bus_we_d       = bus_we_q;
        bus_addr_d     = bus_addr_q;
        bus_be_d       = bus_be_q;
        bus_wdata_d    = bus_wdata_q;
        exc_d          = exc_q;
        rdata_d        = rdata_q;
        mmu_addr_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sext_d  = sign_ext;
                    off_d   = vaddr[1:0];
                    wdata_d = wdata;
                    if (misaligned) begin
                        exc_d   = we ? EXC_ADES : EXC_ADEL;
                        rdata_d = '0;
                        state_d = S_DONE;
                    end else begin
                        mmu_addr_valid = 1'b1;
                        state_d        = S_TRANS;
                    end
                end
            end
            S_TRANS: begin
                if (mmu_exc != 2'd0) begin
                    exc_d   = 3'd2 + {1'b0, mmu_exc};
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    bus_addr_d = {mmu_paddr[31:2], 2'b00};
                    bus_io_d   = mmu_io;
                    bus_we_d   = we_q;
                    bus_req_d  = 1'b1;
                    cnt_d      = '0;
                    case (size_q)
                        2'd0: begin
                            bus_be_d    = 4'b0001 << off_q;
                            bus_wdata_d = {4{wdata_q[7:0]}};
                        end
                        2'd1: begin
                            bus_be_d    = off_q[1] ? 4'b1100 : 4'b0011;
                            bus_wdata_d = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            bus_be_d    = 4'b1111;
                            bus_wdata_d = wdata_q;
                        end
                    endcase
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // An ack arriving on the last permitted cycle still completes normally.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    rdata_d   = we_q ? '0 : load_val;
                    exc_d     = EXC_NONE;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_req_d = 1'b0;
                    rdata_d   = '0;
                    exc_d     = EXC_BUS;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (res) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            sext_q      <= 1'b0;
            off_q       <= 2'd0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_io_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
            exc_q       <= EXC_NONE;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_io_q    <= bus_io_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            exc_q       <= exc_d;
            rdata_q     <= rdata_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign rdata     = rdata_q;
    assign exc       = exc_q;
    assign mmu_vaddr = vaddr;
    assign mmu_write = we;
    assign bus_req   = bus_req_q;
    assign bus_io    = bus_io_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
